// File: rtl/dcache_pkg.sv
// Definitions shared by the dcache data, tag and fill blocks: line geometry
// and the fill-engine state encoding.
package dcache_pkg;

  localparam int LINE_WIDTH = 512;
  localparam int WORD_BITS  = 64;
  localparam int BEATS      = LINE_WIDTH / WORD_BITS;
  localparam int LOG_BEATS  = $clog2(BEATS);

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_COLLECT,
    FILL_WRITE
  } fill_state_t;

endpackage

// File: rtl/dcache_fill_unit.sv
// Line-fill engine: gathers wrapped memory beats into a line buffer, forwards
// the critical word early, then writes the whole line to the data SRAM.
module dcache_fill_unit
  import dcache_pkg::*;
#(
  parameter  int WIDTH         = LINE_WIDTH,
  parameter  int LOG_NUM_ROWS  = 9,
  parameter  int WORD_SIZE     = WORD_BITS,
  localparam int NUM_BEATS     = WIDTH / WORD_SIZE,
  localparam int LOG_NUM_BEATS = $clog2(NUM_BEATS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fill_req_valid,
  output logic                     fill_req_ready,
  input  logic [LOG_NUM_ROWS-1:0]  fill_req_row,
  input  logic [LOG_NUM_BEATS-1:0] fill_req_word,
  input  logic                     fill_abort,
  input  logic                     mem_beat_valid,
  output logic                     mem_beat_ready,
  input  logic [WORD_SIZE-1:0]     mem_beat_data,
  output logic                     crit_valid,
  output logic [WORD_SIZE-1:0]     crit_data,
  output logic [LOG_NUM_ROWS-1:0]  sram_writeAddr,
  output logic [WIDTH-1:0]         sram_writeData,
  output logic [NUM_BEATS-1:0]     sram_writeEnable,
  output logic                     fill_done,
  output logic [LOG_NUM_ROWS-1:0]  fill_row
);

  fill_state_t                               state;
  logic [NUM_BEATS-1:0][WORD_SIZE-1:0]       line;
  logic [NUM_BEATS-1:0][WORD_SIZE-1:0]       line_next;
  logic [LOG_NUM_BEATS-1:0]                  ptr;
  logic [LOG_NUM_BEATS-1:0]                  cnt;
  logic [LOG_NUM_ROWS-1:0]                   row_q;
  logic                                      beat_take;
  logic                                      last_beat;

  // An abort in the same cycle as a beat wins: the beat is dropped.
  assign beat_take = (state == FILL_COLLECT) && mem_beat_valid && !fill_abort;
  assign last_beat = beat_take && (cnt == LOG_NUM_BEATS'(NUM_BEATS - 1));

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    line_next = line;
    if (beat_take) line_next[ptr] = mem_beat_data;
  end

  assign fill_req_ready   = (state == FILL_IDLE) && !reset;
  assign mem_beat_ready   = (state == FILL_COLLECT);
  assign sram_writeEnable = ((state == FILL_WRITE) && !reset) ? {NUM_BEATS{1'b1}} : '0;
  assign fill_done        = (state == FILL_WRITE) && !reset;
  assign fill_row         = row_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the line buffer is a flop array, not an SRAM, so clearing it on reset is cheap and deterministic.
      state          <= FILL_IDLE;
      line           <= '0;
      ptr            <= '0;
      cnt            <= '0;
      row_q          <= '0;
      crit_valid     <= 1'b0;
      crit_data      <= '0;
      sram_writeAddr <= '0;
      sram_writeData <= '0;
    end else begin
      // The pulse is registered, so it still fires if an abort arrives in its cycle.
      crit_valid <= beat_take && (cnt == '0);
      case (state)
        FILL_IDLE: begin
          if (fill_req_valid) begin
            row_q <= fill_req_row;
            ptr   <= fill_req_word;
            cnt   <= '0;
            state <= FILL_COLLECT;
          end
        end
        FILL_COLLECT: begin
          if (fill_abort) begin
            state <= FILL_IDLE;
          end else if (beat_take) begin
            line <= line_next;
            ptr  <= ptr + 1'b1;
            cnt  <= cnt + 1'b1;
            if (cnt == '0) crit_data <= mem_beat_data;
            if (last_beat) begin
              // Capture the write port payload here so it holds after WRITE.
              sram_writeAddr <= row_q;
              sram_writeData <= line_next;
              state          <= FILL_WRITE;
            end
          end
        end
        FILL_WRITE: state <= FILL_IDLE;
        default:    state <= FILL_IDLE;
      endcase
    end
  end

endmodule
